// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine: state encoding and the zero-operand decision.
package gcd_pkg;

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_CALC   = 2'b01;
    localparam logic [1:0] S_FINISH = 2'b10;

    // Returns 1 when the operand pair must be reported as an error under the given policy.
    // zero_err=1: any zero operand is an error; zero_err=0: only gcd(0,0) is an error.
    function automatic logic zero_fault(input logic [63:0] a, input logic [63:0] b,
                                        input logic zero_err);
        if (zero_err) begin
            return (a == 64'd0) || (b == 64'd0);
        end
        return (a == 64'd0) && (b == 64'd0);
    endfunction

endpackage

// File: rtl/gcd_engine_if.sv
// Request/result bundle between a control agent (master) and the GCD engine (slave).
//
// Handshake: a request transfers on a rising edge where START=1 and READY=1; A/B are
// sampled on that edge only. A result is offered while DONE=1 (Y/ERROR/ITERS stable)
// and is consumed on a rising edge where DONE=1 and ACK=1. START is ignored when
// READY=0 and ACK is ignored when DONE=0.
interface gcd_engine_if #(
    parameter int WIDTH  = 8,
    parameter int ITER_W = WIDTH
) ();
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic              START;
    logic              READY;
    logic              BUSY;
    logic              ACK;
    logic [WIDTH-1:0]  Y;
    logic              DONE;
    logic              ERROR;
    logic [ITER_W-1:0] ITERS;

    modport master (
        output A, B, START, ACK,
        input  READY, BUSY, Y, DONE, ERROR, ITERS
    );

    modport slave (
        input  A, B, START, ACK,
        output READY, BUSY, Y, DONE, ERROR, ITERS
    );
endinterface

// File: rtl/gcd_sub_step.sv
// One compare/subtract step of the subtractive Euclid algorithm.
module gcd_sub_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] rb,
    output logic             eq,
    output logic             a_gt_b,
    output logic [WIDTH-1:0] next_ra,
    output logic [WIDTH-1:0] next_rb
);
    // Both differences are produced; the caller only uses the one whose minuend is larger,
    // so the selected result never underflows.
    always_comb begin
        eq      = (ra == rb);
        a_gt_b  = (ra > rb);
        next_ra = ra - rb;
        next_rb = rb - ra;
    end
endmodule

// File: rtl/gcd_engine.sv
// Iterative GCD engine with configurable zero policy, saturating step counter and
// result hold until acknowledged.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ITER_W   = WIDTH,
    parameter bit ZERO_ERR = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    gcd_engine_if.slave         bus,
    output logic [1:0]          state_dbg
);
    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  ra_q, ra_d;
    logic [WIDTH-1:0]  rb_q, rb_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [ITER_W-1:0] iters_q, iters_d;
    logic              error_q, error_d;

    logic              step_eq;
    logic              step_gt;
    logic [WIDTH-1:0]  step_ra;
    logic [WIDTH-1:0]  step_rb;

    logic              any_zero;
    logic              fault;
    logic              ready_o, busy_o, done_o;

    gcd_sub_step #(.WIDTH(WIDTH)) u_step (
        .ra      (ra_q),
        .rb      (rb_q),
        .eq      (step_eq),
        .a_gt_b  (step_gt),
        .next_ra (step_ra),
        .next_rb (step_rb)
    );

    // Zero-operand decode on the live request operands.
    always_comb begin
        any_zero = (bus.A == '0) || (bus.B == '0);
        fault    = zero_fault(64'(bus.A), 64'(bus.B), ZERO_ERR);
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            y_q     <= '0;
            iters_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            y_q     <= y_d;
            iters_q <= iters_d;
            error_q <= error_d;
        end
    end

    // Next-state: any zero operand short-cuts straight to FINISH; illegal code returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.START) state_d = any_zero ? S_FINISH : S_CALC;
            S_CALC:   if (step_eq) state_d = S_FINISH;
            S_FINISH: if (bus.ACK) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath updates: load on accepted START, one subtract per CALC cycle, hold otherwise.
    always_comb begin
        ra_d    = ra_q;
        rb_d    = rb_q;
        y_d     = y_q;
        iters_d = iters_q;
        error_d = error_q;
        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    ra_d    = bus.A;
                    rb_d    = bus.B;
                    iters_d = '0;
                    error_d = 1'b0;
                    if (fault) begin
                        y_d     = '0;
                        error_d = 1'b1;
                    end else if (any_zero) begin
                        // Only one operand can be zero here, so OR yields the other one.
                        y_d = bus.A | bus.B;
                    end
                end
            end
            S_CALC: begin
                if (step_eq) begin
                    y_d = ra_q;
                end else begin
                    if (step_gt) ra_d = step_ra;
                    else         rb_d = step_rb;
                    if (iters_q != {ITER_W{1'b1}}) iters_d = iters_q + ITER_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Status outputs decoded from the state register; the illegal code drives none of them.
    always_comb begin
        ready_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            S_IDLE:   ready_o = 1'b1;
            S_CALC:   busy_o  = 1'b1;
            S_FINISH: done_o  = 1'b1;
            default:  ;
        endcase
    end

    assign bus.READY = ready_o;
    assign bus.BUSY  = busy_o;
    assign bus.DONE  = done_o;
    assign bus.Y     = y_q;
    assign bus.ERROR = error_q;
    assign bus.ITERS = iters_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Directed and random checks of gcd_engine in three configurations sharing one clock.
module tb_gcd_engine;
    import gcd_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] a_in, b_in;
    logic        start_in, ack_in;
    int          sel;

    int n_checks = 0;
    int n_fail   = 0;

    // dut0: WIDTH=8, ZERO_ERR=1; dut1: WIDTH=8, ZERO_ERR=0; dut2: WIDTH=16, ITER_W=4
    gcd_engine_if #(.WIDTH(8),  .ITER_W(8)) if0 ();
    gcd_engine_if #(.WIDTH(8),  .ITER_W(8)) if1 ();
    gcd_engine_if #(.WIDTH(16), .ITER_W(4)) if2 ();
    logic [1:0] st0, st1, st2;

    assign if0.A = a_in[7:0];
    assign if0.B = b_in[7:0];
    assign if0.START = start_in && (sel == 0);
    assign if0.ACK   = ack_in   && (sel == 0);
    assign if1.A = a_in[7:0];
    assign if1.B = b_in[7:0];
    assign if1.START = start_in && (sel == 1);
    assign if1.ACK   = ack_in   && (sel == 1);
    assign if2.A = a_in;
    assign if2.B = b_in;
    assign if2.START = start_in && (sel == 2);
    assign if2.ACK   = ack_in   && (sel == 2);

    gcd_engine #(.WIDTH(8),  .ITER_W(8), .ZERO_ERR(1'b1)) dut0 (
        .CLK(clk), .RST(rst), .bus(if0), .state_dbg(st0));
    gcd_engine #(.WIDTH(8),  .ITER_W(8), .ZERO_ERR(1'b0)) dut1 (
        .CLK(clk), .RST(rst), .bus(if1), .state_dbg(st1));
    gcd_engine #(.WIDTH(16), .ITER_W(4), .ZERO_ERR(1'b1)) dut2 (
        .CLK(clk), .RST(rst), .bus(if2), .state_dbg(st2));

    logic        obs_ready, obs_busy, obs_done, obs_err;
    logic [15:0] obs_y;
    logic [7:0]  obs_iters;
    logic [1:0]  obs_state;

    always_comb begin
        obs_ready = if0.READY;
        obs_busy  = if0.BUSY;
        obs_done  = if0.DONE;
        obs_err   = if0.ERROR;
        obs_y     = {8'd0, if0.Y};
        obs_iters = if0.ITERS;
        obs_state = st0;
        if (sel == 1) begin
            obs_ready = if1.READY;
            obs_busy  = if1.BUSY;
            obs_done  = if1.DONE;
            obs_err   = if1.ERROR;
            obs_y     = {8'd0, if1.Y};
            obs_iters = if1.ITERS;
            obs_state = st1;
        end else if (sel == 2) begin
            obs_ready = if2.READY;
            obs_busy  = if2.BUSY;
            obs_done  = if2.DONE;
            obs_err   = if2.ERROR;
            obs_y     = if2.Y;
            obs_iters = {4'd0, if2.ITERS};
            obs_state = st2;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_excl(input string tag);
        check({tag, " ready/busy/done exclusive"},
              32'(int'(obs_ready) + int'(obs_busy) + int'(obs_done) <= 1), 32'd1);
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issues one request and waits for DONE; edges counts rising edges including the START edge.
    task automatic run_op(input string tag, input int k, input logic [15:0] a,
                          input logic [15:0] b, output int edges);
        int w;
        sel = k;
        w = 0;
        while (!obs_ready && w < 50) begin
            tick();
            w++;
        end
        if (!obs_ready) check({tag, " ready before start"}, 32'(obs_ready), 32'd1);
        a_in = a;
        b_in = b;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        edges = 1;
        while (!obs_done && edges < 3000) begin
            check_excl(tag);
            tick();
            edges++;
        end
        if (!obs_done) check({tag, " done timeout"}, 32'(obs_done), 32'd1);
    endtask

    // Holds ACK low for dly cycles (result must stay put), then acknowledges.
    task automatic release_op(input string tag, input int dly, input logic [15:0] y_hold);
        for (int i = 0; i < dly; i++) begin
            tick();
            check_excl(tag);
            check({tag, " done held"}, 32'(obs_done), 32'd1);
            check({tag, " y held"}, 32'(obs_y), 32'(y_hold));
        end
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        check({tag, " ready after ack"}, 32'(obs_ready), 32'd1);
        check({tag, " done after ack"}, 32'(obs_done), 32'd0);
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_gcd(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int ref_steps(input int a, input int b);
        int x = a;
        int y = b;
        int n = 0;
        while (x != y) begin
            if (x > y) x = x - y;
            else       y = y - x;
            n++;
        end
        return n;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int edges;
        int seen;
        int ra, rb, dly, exp_y, exp_n;
        logic exp_e;

        rst = 1'b1;
        start_in = 1'b0;
        ack_in = 1'b0;
        a_in = '0;
        b_in = '0;
        sel = 0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state of all three instances
        for (int k = 0; k < 3; k++) begin
            sel = k;
            check("reset ready", 32'(obs_ready), 32'd1);
            check("reset busy",  32'(obs_busy),  32'd0);
            check("reset done",  32'(obs_done),  32'd0);
            check("reset y",     32'(obs_y),     32'd0);
            check("reset iters", 32'(obs_iters), 32'd0);
            check("reset state", 32'(obs_state), 32'(S_IDLE));
        end

        // gcd(12,8): 12-8=4, 8-4=4 -> two steps, DONE on the 4th edge counting START
        run_op("g12_8", 0, 16'd12, 16'd8, edges);
        check("g12_8 edges", 32'(edges), 32'd4);
        check("g12_8 y", 32'(obs_y), 32'd4);
        check("g12_8 iters", 32'(obs_iters), 32'd2);
        check("g12_8 err", 32'(obs_err), 32'd0);
        release_op("g12_8", 5, 16'd4);

        // Reset during CALC discards the operation
        sel = 0;
        a_in = 16'd255;
        b_in = 16'd1;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        repeat (9) tick();
        check("rst_mid busy", 32'(obs_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid ready", 32'(obs_ready), 32'd1);
        check("rst_mid done",  32'(obs_done),  32'd0);
        check("rst_mid y",     32'(obs_y),     32'd0);
        check("rst_mid iters", 32'(obs_iters), 32'd0);
        seen = 0;
        repeat (300) begin
            tick();
            if (obs_done) seen = 1;
        end
        check("rst_mid no done", 32'(seen), 32'd0);

        // Zero-operand policy
        run_op("z_err", 0, 16'd0, 16'd9, edges);
        check("z_err edges", 32'(edges), 32'd1);
        check("z_err err", 32'(obs_err), 32'd1);
        check("z_err y", 32'(obs_y), 32'd0);
        release_op("z_err", 1, 16'd0);

        run_op("z_pass", 1, 16'd0, 16'd9, edges);
        check("z_pass edges", 32'(edges), 32'd1);
        check("z_pass err", 32'(obs_err), 32'd0);
        check("z_pass y", 32'(obs_y), 32'd9);
        release_op("z_pass", 0, 16'd9);

        run_op("z_pass_b", 1, 16'd23, 16'd0, edges);
        check("z_pass_b err", 32'(obs_err), 32'd0);
        check("z_pass_b y", 32'(obs_y), 32'd23);
        release_op("z_pass_b", 0, 16'd23);

        run_op("z_both", 1, 16'd0, 16'd0, edges);
        check("z_both edges", 32'(edges), 32'd1);
        check("z_both err", 32'(obs_err), 32'd1);
        check("z_both y", 32'(obs_y), 32'd0);
        release_op("z_both", 0, 16'd0);

        // Equal operands, START ignored in FINISH and on the ACK edge
        run_op("eq37", 0, 16'd37, 16'd37, edges);
        check("eq37 edges", 32'(edges), 32'd2);
        check("eq37 y", 32'(obs_y), 32'd37);
        check("eq37 iters", 32'(obs_iters), 32'd0);
        a_in = 16'd6;
        b_in = 16'd10;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("eq37 start in finish done", 32'(obs_done), 32'd1);
        check("eq37 start in finish y", 32'(obs_y), 32'd37);
        start_in = 1'b1;
        ack_in = 1'b1;
        tick();
        start_in = 1'b0;
        ack_in = 1'b0;
        check("eq37 start on ack ready", 32'(obs_ready), 32'd1);
        check("eq37 start on ack busy", 32'(obs_busy), 32'd0);
        tick();
        check("eq37 still idle", 32'(obs_ready), 32'd1);
        check("eq37 y kept", 32'(obs_y), 32'd37);

        // 16-bit width with a 4-bit saturating counter: 999 steps
        run_op("w16", 2, 16'd1000, 16'd1, edges);
        check("w16 edges", 32'(edges), 32'd1001);
        check("w16 y", 32'(obs_y), 32'd1);
        check("w16 iters sat", 32'(obs_iters), 32'd15);
        release_op("w16", 1, 16'd1);
        run_op("w16max", 2, 16'd65535, 16'd65535, edges);
        check("w16max y", 32'(obs_y), 32'd65535);
        check("w16max iters", 32'(obs_iters), 32'd0);
        release_op("w16max", 0, 16'd65535);

        // Random operand pairs against the reference Euclid result
        for (int i = 0; i < 500; i++) begin
            ra = int'($urandom_range(0, 255));
            rb = int'($urandom_range(0, 255));
            dly = int'($urandom_range(0, 4));
            exp_e = zero_fault(64'(ra), 64'(rb), 1'b1);
            if (exp_e) begin
                exp_y = 0;
                exp_n = 0;
            end else begin
                exp_y = ref_gcd(ra, rb);
                exp_n = ref_steps(ra, rb);
            end
            run_op("rnd", 0, 16'(ra), 16'(rb), edges);
            check("rnd y", 32'(obs_y), 32'(exp_y));
            check("rnd iters", 32'(obs_iters), 32'(exp_n));
            check("rnd err", 32'(obs_err), 32'(exp_e));
            check("rnd edges", 32'(edges), exp_e ? 32'd1 : 32'(exp_n + 2));
            release_op("rnd", dly, 16'(exp_y));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
